// File: rtl/tile_draw_scheduler.sv
// Arbitrates two tile-draw requesters onto one 8x8 tile datapath; flash draws restore the base colour after a hold.
// Optional ROUND_ROBIN_EN: alternate on ties instead of fixed A-first priority.
module tile_draw_scheduler #(
   parameter int PIXELS      = 64,
   parameter int HOLD_CYCLES = 12500000,
   parameter int PW          = 6,
   parameter int HW          = 24
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_a,
   input  logic [1:0]    tile_a,
   input  logic          flash_a,
   input  logic          req_b,
   input  logic [1:0]    tile_b,
   input  logic          flash_b,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic          done_a,
   output logic          done_b,
   output logic          busy,
   output logic [1:0]    tile_num,
   output logic          ld_tile,
   output logic          ld_flash,
   output logic          writeEnable,
   output logic          counterEnable,
   output logic [PW-1:0] pixel_count,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAW  = 3'd2,
      S_HOLD  = 3'd3,
      S_RLOAD = 3'd4,
      S_RDRAW = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   state_t        state_q;
   logic          owner_b_q;
   logic          flash_q;
   logic [1:0]    tile_q;
   logic [PW-1:0] pixel_q;
   logic [HW-1:0] hold_q;
   logic          gnt_a_q, gnt_b_q, done_a_q, done_b_q;
   logic          busy_q, ld_tile_q, ld_flash_q, we_q;
   logic          pick_b;
   logic          sel_flash;

`ifdef ROUND_ROBIN_EN
   // Remembers whether B took the last grant; reset value lets A win first.
   logic rr_last_b_q;

   always_comb begin
      pick_b = req_b && (!req_a || !rr_last_b_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_last_b_q <= 1'b1;
      end else if (state_q == S_IDLE && (req_a || req_b)) begin
         rr_last_b_q <= pick_b;
      end
   end
`else
   always_comb begin
      pick_b = req_b && !req_a;
   end
`endif

   always_comb begin
      sel_flash = pick_b ? flash_b : flash_a;
   end

   // Single-process Moore FSM; every output is a register set on state entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_b_q  <= 1'b0;
         flash_q    <= 1'b0;
         tile_q     <= 2'd0;
         pixel_q    <= '0;
         hold_q     <= '0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         done_a_q   <= 1'b0;
         done_b_q   <= 1'b0;
         busy_q     <= 1'b0;
         ld_tile_q  <= 1'b0;
         ld_flash_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         done_a_q   <= 1'b0;
         done_b_q   <= 1'b0;
         ld_tile_q  <= 1'b0;
         ld_flash_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_a || req_b) begin
                  state_q    <= S_LOAD;
                  owner_b_q  <= pick_b;
                  tile_q     <= pick_b ? tile_b : tile_a;
                  flash_q    <= sel_flash;
                  gnt_a_q    <= !pick_b;
                  gnt_b_q    <= pick_b;
                  ld_flash_q <= sel_flash;
                  ld_tile_q  <= !sel_flash;
                  pixel_q    <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q <= S_DRAW;
               we_q    <= 1'b1;
            end
            S_DRAW: begin
               if (pixel_q == PIX_LAST) begin
                  we_q <= 1'b0;
                  if (flash_q) begin
                     state_q <= S_HOLD;
                     hold_q  <= '0;
                  end else begin
                     state_q  <= S_DONE;
                     done_a_q <= !owner_b_q;
                     done_b_q <= owner_b_q;
                  end
               end else begin
                  pixel_q <= pixel_q + 1'b1;
               end
            end
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  state_q   <= S_RLOAD;
                  ld_tile_q <= 1'b1;
                  pixel_q   <= '0;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            S_RLOAD: begin
               state_q <= S_RDRAW;
               we_q    <= 1'b1;
            end
            S_RDRAW: begin
               if (pixel_q == PIX_LAST) begin
                  we_q     <= 1'b0;
                  state_q  <= S_DONE;
                  done_a_q <= !owner_b_q;
                  done_b_q <= owner_b_q;
               end else begin
                  pixel_q <= pixel_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               pixel_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_a         = gnt_a_q;
   assign gnt_b         = gnt_b_q;
   assign done_a        = done_a_q;
   assign done_b        = done_b_q;
   assign busy          = busy_q;
   assign tile_num      = tile_q;
   assign ld_tile       = ld_tile_q;
   assign ld_flash      = ld_flash_q;
   assign writeEnable   = we_q;
   assign counterEnable = we_q;
   assign pixel_count   = pixel_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed bench for tile_draw_scheduler with PIXELS=64, HOLD_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tile_draw_scheduler;

   localparam int PW = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_a = 1'b0, flash_a = 1'b0, req_b = 1'b0, flash_b = 1'b0;
   logic [1:0]    tile_a = 2'd0, tile_b = 2'd0;
   logic          gnt_a, gnt_b, done_a, done_b, busy, ld_tile, ld_flash;
   logic          writeEnable, counterEnable;
   logic [1:0]    tile_num;
   logic [PW-1:0] pixel_count;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   tile_draw_scheduler #(.PIXELS(64), .HOLD_CYCLES(4), .PW(PW), .HW(24)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .tile_a(tile_a), .flash_a(flash_a),
      .req_b(req_b), .tile_b(tile_b), .flash_b(flash_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
      .busy(busy), .tile_num(tile_num), .ld_tile(ld_tile), .ld_flash(ld_flash),
      .writeEnable(writeEnable), .counterEnable(counterEnable),
      .pixel_count(pixel_count), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({gnt_a, gnt_b, done_a, done_b, busy, tile_num, ld_tile, ld_flash,
           writeEnable, counterEnable, pixel_count, dbg_state} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b we=%b pix=%0d state=%0d, want all 0",
                  busy, writeEnable, pixel_count, dbg_state);
      end
      reset = 1'b0;
   endtask

   task automatic test_plain_draw();
      int we_cnt = 0, pix_err = 0, done_k = -1;
      tile_a = 2'd2; flash_a = 1'b0; req_a = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clock);
         if (k == 1) begin
            checks++;
            if ({gnt_a, gnt_b, ld_tile, ld_flash, tile_num, busy} !== 7'b1010101) begin
               errors++;
               $display("FAIL plain_grant: gnt_a=%b gnt_b=%b ld_tile=%b ld_flash=%b tile=%0d busy=%b, want 1 0 1 0 2 1",
                        gnt_a, gnt_b, ld_tile, ld_flash, tile_num, busy);
            end
            req_a = 1'b0;
         end
         if (writeEnable) begin
            we_cnt++;
            if (k < 2 || k > 65 || pixel_count !== PW'(k - 2) || counterEnable !== 1'b1) pix_err++;
         end
         if (done_a && done_k < 0) done_k = k;
         if (done_b) pix_err++;
      end
      checks++;
      if (we_cnt != 64 || pix_err != 0) begin
         errors++;
         $display("FAIL plain_pixels: writes=%0d bad=%0d, want 64 writes 0 bad", we_cnt, pix_err);
      end
      checks++;
      if (done_k != 66) begin
         errors++;
         $display("FAIL plain_done: done_a at %0d, want 66", done_k);
      end
      checks++;
      if (busy !== 1'b0 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL plain_idle: busy=%b state=%0d, want 0 0", busy, dbg_state);
      end
   endtask

   task automatic test_flash_draw();
      int we_cnt = 0, pix_err = 0, done_k = -1, rld_k = -1, hold_err = 0;
      bit exp_we;
      tile_b = 2'd1; flash_b = 1'b1; req_b = 1'b1;
      for (int k = 1; k <= 140; k++) begin
         @(negedge clock);
         if (k == 1) begin
            checks++;
            if ({gnt_a, gnt_b, ld_tile, ld_flash, tile_num} !== 6'b010101) begin
               errors++;
               $display("FAIL flash_grant: gnt_a=%b gnt_b=%b ld_tile=%b ld_flash=%b tile=%0d, want 0 1 0 1 1",
                        gnt_a, gnt_b, ld_tile, ld_flash, tile_num);
            end
            req_b = 1'b0;
         end
         exp_we = (k >= 2 && k <= 65) || (k >= 71 && k <= 134);
         if (writeEnable) begin
            we_cnt++;
            if (!exp_we) pix_err++;
            else if (pixel_count !== PW'((k <= 65) ? k - 2 : k - 71)) pix_err++;
         end else if (exp_we) pix_err++;
         if (k >= 66 && k <= 69 && (ld_tile || ld_flash || writeEnable || counterEnable || !busy)) hold_err++;
         if (k > 1 && ld_tile && rld_k < 0) rld_k = k;
         if (done_b && done_k < 0) done_k = k;
         if (done_a) pix_err++;
      end
      checks++;
      if (we_cnt != 128 || pix_err != 0) begin
         errors++;
         $display("FAIL flash_pixels: writes=%0d bad=%0d, want 128 writes 0 bad", we_cnt, pix_err);
      end
      checks++;
      if (hold_err != 0 || rld_k != 70) begin
         errors++;
         $display("FAIL flash_hold: hold_bad=%0d restore_load at %0d, want 0 and 70", hold_err, rld_k);
      end
      checks++;
      if (done_k != 135) begin
         errors++;
         $display("FAIL flash_done: done_b at %0d, want 135", done_k);
      end
      flash_b = 1'b0;
   endtask

   task automatic test_tie();
      int n = 0, both = 0;
      int gk[3];
      logic [2:0] got = 3'b000;
      logic [2:0] exp_order;
`ifdef ROUND_ROBIN_EN
      exp_order = 3'b010;
`else
      exp_order = 3'b000;
`endif
      tile_a = 2'd0; tile_b = 2'd3; flash_a = 1'b0; flash_b = 1'b0;
      req_a = 1'b1; req_b = 1'b1;
      for (int k = 1; k <= 210; k++) begin
         @(negedge clock);
         if (gnt_a && gnt_b) both++;
         if (gnt_a || gnt_b) begin
            if (n < 3) begin
               got[n] = gnt_b;
               gk[n] = k;
            end
            n++;
            if (n == 3) begin
               req_a = 1'b0; req_b = 1'b0;
            end
         end
      end
      checks++;
      if (n != 3 || both != 0 || got !== exp_order) begin
         errors++;
         $display("FAIL tie_order: grants=%0d double=%0d order(bit=B)=%b, want 3 0 %b",
                  n, both, got, exp_order);
      end
      checks++;
      if (n < 3 || gk[0] != 1 || gk[1] != 68 || gk[2] != 135) begin
         errors++;
         $display("FAIL back_to_back: grant cycles %0d %0d %0d, want 1 68 135",
                  gk[0], gk[1], gk[2]);
      end
   endtask

   task automatic test_input_change();
      int tile_err = 0, we_cnt = 0, done_k = -1, gnt_b_k = -1;
      tile_a = 2'd3; flash_a = 1'b0; req_a = 1'b1;
      for (int k = 1; k <= 140; k++) begin
         @(negedge clock);
         if (k == 1) req_a = 1'b0;
         if (k == 10) begin
            tile_a = 2'd0; flash_a = 1'b1; req_a = 1'b1;
            tile_b = 2'd2; flash_b = 1'b0; req_b = 1'b1;
         end
         if (k == 11) req_a = 1'b0;
         if (k >= 1 && k <= 66 && tile_num !== 2'd3) tile_err++;
         if (k <= 66 && writeEnable) we_cnt++;
         if (done_a && done_k < 0) done_k = k;
         if (gnt_b && gnt_b_k < 0) begin
            gnt_b_k = k;
            req_b = 1'b0;
         end
      end
      checks++;
      if (tile_err != 0 || we_cnt != 64) begin
         errors++;
         $display("FAIL change_tile: tile_bad=%0d writes=%0d, want 0 and 64", tile_err, we_cnt);
      end
      checks++;
      if (done_k != 66) begin
         errors++;
         $display("FAIL change_done: done_a at %0d, want 66", done_k);
      end
      checks++;
      if (gnt_b_k != 68) begin
         errors++;
         $display("FAIL wait_loser: gnt_b at %0d, want 68", gnt_b_k);
      end
   endtask

   task automatic test_reset_abort();
      int stray = 0, done_k = -1, gnt_k = -1;
      tile_a = 2'd1; flash_a = 1'b1; req_a = 1'b1;
      for (int k = 1; k <= 101; k++) begin
         @(negedge clock);
         if (k == 1) req_a = 1'b0;
      end
      checks++;
      if (writeEnable !== 1'b1 || pixel_count !== 6'd30 || dbg_state !== 3'd5) begin
         errors++;
         $display("FAIL abort_point: we=%b pix=%0d state=%0d, want 1 30 5",
                  writeEnable, pixel_count, dbg_state);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({gnt_a, gnt_b, done_a, done_b, busy, tile_num, ld_tile, ld_flash,
           writeEnable, counterEnable, pixel_count, dbg_state} !== 20'd0) begin
         errors++;
         $display("FAIL abort_outputs: busy=%b we=%b pix=%0d state=%0d tile=%0d, want all 0",
                  busy, writeEnable, pixel_count, dbg_state, tile_num);
      end
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (done_a || done_b || busy || writeEnable) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL abort_quiet: stray activity cycles=%0d, want 0", stray);
      end
      tile_a = 2'd2; flash_a = 1'b0; req_a = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clock);
         if (gnt_a && gnt_k < 0) begin
            gnt_k = k;
            req_a = 1'b0;
         end
         if (done_a && done_k < 0) done_k = k;
      end
      checks++;
      if (gnt_k != 1 || done_k != 66) begin
         errors++;
         $display("FAIL abort_recover: gnt_a at %0d done_a at %0d, want 1 and 66", gnt_k, done_k);
      end
   endtask

   initial begin
      test_reset();
      test_plain_draw();
      @(negedge clock);
      test_flash_draw();
      @(negedge clock);
      test_tie();
      @(negedge clock);
      test_input_change();
      @(negedge clock);
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
